// File: rtl/cascade_eval.sv
// Sequential Haar-cascade evaluator for one detection window: feature parameters and corner samples arrive as streams.
// Each feature takes 6 cycles (FETCH, 4x CORNER, CMP). The cascade exits on the first failed stage.
module cascade_eval #(
  parameter  int N_RECT        = 3,
  parameter  int W_DATA        = 18,
  parameter  int W_WEIGHT      = 3,
  parameter  int W_STDDEV      = 36,
  parameter  int W_FEAT_TH     = 13,
  parameter  int W_LEAF        = 14,
  parameter  int W_STAGE_TH    = 11,
  parameter  int STAGE_NUM     = 25,
  parameter  int MAX_WEAKCOUNT = 211,
  localparam int W_STAGE       = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         stddev_valid,
  output logic                         stddev_ready,
  input  logic [W_STDDEV-1:0]          stddev_data,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [N_RECT*W_DATA-1:0]     din_data,
  input  logic                         param_valid,
  output logic                         param_ready,
  input  logic [N_RECT*W_WEIGHT-1:0]   param_weights,
  input  logic [W_FEAT_TH-1:0]         param_feat_th,
  input  logic [W_LEAF-1:0]            param_leaf_l,
  input  logic [W_LEAF-1:0]            param_leaf_r,
  input  logic                         param_last_weak,
  input  logic [W_STAGE_TH-1:0]        param_stage_th,
  input  logic                         param_last_stage,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         result_data,
  output logic [W_STAGE-1:0]           result_stage
);

  localparam int W_FSUM = W_DATA + W_WEIGHT + $clog2(N_RECT) + 3;
  localparam int W_LHS  = W_FSUM + 12;
  localparam int W_RHS  = W_FEAT_TH + W_STDDEV + 1;
  localparam int W_CMP  = ((W_LHS > W_RHS) ? W_LHS : W_RHS) + 1;
  localparam int W_ACC  = W_LEAF + $clog2(MAX_WEAKCOUNT) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, CORNER, CMP, RESULT} state_t;

  state_t state, state_nxt;

  logic [W_STDDEV-1:0]        stddev_q;
  logic [N_RECT*W_WEIGHT-1:0] weights_q;
  logic signed [W_FEAT_TH-1:0]  feat_th_q;
  logic signed [W_LEAF-1:0]     leaf_l_q;
  logic signed [W_LEAF-1:0]     leaf_r_q;
  logic signed [W_STAGE_TH-1:0] stage_th_q;
  logic                       last_weak_q;
  logic                       last_stage_q;
  logic signed [W_FSUM-1:0]   fsum;
  logic [1:0]                 corner_cnt;
  logic signed [W_ACC-1:0]    stage_acc;
  logic [W_STAGE-1:0]         stage_cnt;

  logic signed [W_FSUM-1:0]   beat_sum, w_ext, d_ext, fsum_nxt;
  logic signed [W_CMP-1:0]    cmp_lhs, cmp_rhs, th_ext, sd_ext;
  logic signed [W_LEAF-1:0]   leaf_sel;
  logic signed [W_ACC-1:0]    acc_new, acc_th;
  logic                       stage_pass, is_final;

  assign stddev_ready = (state == IDLE);
  assign param_ready  = (state == FETCH);
  assign din_ready    = (state == CORNER);
  assign result_valid = (state == RESULT);

  // Weighted sum of this beat's corner samples across all rectangles.
  always_comb begin
    beat_sum = '0;
    w_ext    = '0;
    d_ext    = '0;
    for (int i = 0; i < N_RECT; i++) begin
      w_ext    = W_FSUM'($signed(weights_q[i*W_WEIGHT +: W_WEIGHT]));
      d_ext    = W_FSUM'({1'b0, din_data[i*W_DATA +: W_DATA]});
      beat_sum = beat_sum + w_ext * d_ext;
    end
    // TR and BL corners subtract, TL and BR add.
    if (corner_cnt == 2'd1 || corner_cnt == 2'd2) fsum_nxt = fsum - beat_sum;
    else                                          fsum_nxt = fsum + beat_sum;
  end

  always_comb begin
    cmp_lhs    = W_CMP'(fsum);
    cmp_lhs    = cmp_lhs <<< 12;
    th_ext     = W_CMP'(feat_th_q);
    sd_ext     = W_CMP'(stddev_q);
    cmp_rhs    = th_ext * sd_ext;
    leaf_sel   = (cmp_lhs < cmp_rhs) ? leaf_l_q : leaf_r_q;
    acc_new    = stage_acc + W_ACC'(leaf_sel);
    acc_th     = W_ACC'(stage_th_q);
    stage_pass = !(acc_new < acc_th);
    is_final   = last_stage_q || (stage_cnt == W_STAGE'(STAGE_NUM - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stddev_valid) state_nxt = FETCH;
      FETCH:   if (param_valid) state_nxt = CORNER;
      CORNER:  if (din_valid && corner_cnt == 2'd3) state_nxt = CMP;
      CMP: begin
        if (!last_weak_q)     state_nxt = FETCH;
        else if (!stage_pass) state_nxt = RESULT;
        else if (is_final)    state_nxt = RESULT;
        else                  state_nxt = FETCH;
      end
      RESULT:  if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stddev_q     <= '0;
      weights_q    <= '0;
      feat_th_q    <= '0;
      leaf_l_q     <= '0;
      leaf_r_q     <= '0;
      stage_th_q   <= '0;
      last_weak_q  <= 1'b0;
      last_stage_q <= 1'b0;
      fsum         <= '0;
      corner_cnt   <= '0;
      stage_acc    <= '0;
      stage_cnt    <= '0;
      result_data  <= 1'b0;
      result_stage <= '0;
    end else begin
      case (state)
        IDLE: if (stddev_valid) begin
          stddev_q  <= stddev_data;
          stage_acc <= '0;
          stage_cnt <= '0;
        end
        FETCH: if (param_valid) begin
          weights_q    <= param_weights;
          feat_th_q    <= param_feat_th;
          leaf_l_q     <= param_leaf_l;
          leaf_r_q     <= param_leaf_r;
          last_weak_q  <= param_last_weak;
          stage_th_q   <= param_stage_th;
          last_stage_q <= param_last_stage;
          fsum         <= '0;
          corner_cnt   <= '0;
        end
        CORNER: if (din_valid) begin
          fsum       <= fsum_nxt;
          corner_cnt <= corner_cnt + 2'd1;
        end
        CMP: begin
          if (!last_weak_q) begin
            stage_acc <= acc_new;
          end else if (!stage_pass) begin
            result_data  <= 1'b0;
            result_stage <= stage_cnt;
          end else if (is_final) begin
            result_data  <= 1'b1;
            result_stage <= stage_cnt;
          end else begin
            stage_acc <= '0;
            stage_cnt <= stage_cnt + W_STAGE'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
